feed_controller: RTL

Drives one dispensing cycle per accepted request: latches portion size, runs the dispenser motor for that many seconds, then holds a completion second and a cooldown. It produces the `feed` level and 32-bit `duration` consumed by the feed-progress overlay in the VGA path, which counts seconds while `feed` is high and clears when it drops. It sits between the request source (button/processor MMIO) and both the motor driver and the display.

---
 rtl/feed_controller_pkg.sv | 34 +++
 rtl/feed_controller_tick_divider.sv | 31 +++
 rtl/feed_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/feed_controller_pkg.sv
// Shared definitions for the feed controller: state encodings, portion codes,
// dispense durations and the default tick period.
package feed_controller_pkg;

  localparam int unsigned TICK_LIMIT_DEFAULT = 50_000_000;
  localparam int unsigned DIV_MIN_W          = 26;
  localparam int unsigned DUR_W              = 32;
  localparam int unsigned ELAPSED_W          = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;

  localparam logic [1:0] PORTION_SMALL   = 2'd0;
  localparam logic [1:0] PORTION_MEDIUM  = 2'd1;
  localparam logic [1:0] PORTION_LARGE   = 2'd2;
  localparam logic [1:0] PORTION_INVALID = 2'd3;

  localparam logic [DUR_W-1:0] DUR_SMALL  = 32'd5;
  localparam logic [DUR_W-1:0] DUR_MEDIUM = 32'd8;
  localparam logic [DUR_W-1:0] DUR_LARGE  = 32'd11;

  // Seconds of motor run for a portion code; invalid maps to zero.
  function automatic logic [DUR_W-1:0] portion_to_duration(input logic [1:0] p);
    case (p)
      PORTION_SMALL:  portion_to_duration = DUR_SMALL;
      PORTION_MEDIUM: portion_to_duration = DUR_MEDIUM;
      PORTION_LARGE:  portion_to_duration = DUR_LARGE;
      default:        portion_to_duration = '0;
    endcase
  endfunction

endpackage

// File: rtl/feed_controller_tick_divider.sv
// One-second tick generator: counts 0..TICK_LIMIT-1 and flags the last count.
module tick_divider
  import feed_controller_pkg::*;
#(
  parameter int unsigned TICK_LIMIT = TICK_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W =
    ($clog2(TICK_LIMIT) > DIV_MIN_W) ? $clog2(TICK_LIMIT) : DIV_MIN_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_LIMIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/feed_controller.sv
// Feed dispensing sequencer: accepts a portion request, runs the motor for the
// portion's duration, holds one completion second, then cools down.
module feed_controller
  import feed_controller_pkg::*;
#(
  parameter int unsigned TICK_LIMIT     = TICK_LIMIT_DEFAULT,
  parameter int unsigned COOLDOWN_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 feed_req,
  input  logic [1:0]           portion,
  input  logic                 cancel,
  output logic                 feed,
  output logic [DUR_W-1:0]     duration,
  output logic                 motor_en,
  output logic                 busy,
  output logic                 done,
  output logic                 rejected,
  output logic [ELAPSED_W-1:0] elapsed
);

  localparam int unsigned CD_W =
    (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_TICKS - 1);
  localparam logic [ELAPSED_W-1:0] ELAPSED_MAX = '1;

  logic [1:0]           state, state_d;
  logic [DUR_W-1:0]     duration_d;
  logic [ELAPSED_W-1:0] elapsed_d, elapsed_inc;
  logic [CD_W-1:0]      cd_cnt, cd_cnt_d;
  logic                 feed_d, motor_en_d, busy_d, done_d, rejected_d;
  logic                 div_clear, tick;

  tick_divider #(
    .TICK_LIMIT(TICK_LIMIT)
  ) u_tick_divider (
    .clk  (clk),
    .reset(reset),
    .clear(div_clear),
    .tick (tick)
  );

  assign elapsed_inc = (elapsed == ELAPSED_MAX) ? ELAPSED_MAX
                                                 : elapsed + ELAPSED_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    duration_d = duration;
    elapsed_d  = elapsed;
    cd_cnt_d   = cd_cnt;
    done_d     = 1'b0;
    rejected_d = 1'b0;
    div_clear  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (feed_req) begin
          if (portion != PORTION_INVALID) begin
            state_d    = ST_DISPENSE;
            duration_d = portion_to_duration(portion);
            elapsed_d  = '0;
          end else begin
            rejected_d = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        if (cancel) begin
          state_d   = ST_COOLDOWN;
          elapsed_d = '0;
        end else if (tick) begin
          elapsed_d = elapsed_inc;
          if (DUR_W'(elapsed) == duration - DUR_W'(1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cancel) begin
          state_d   = ST_COOLDOWN;
          elapsed_d = '0;
        end else if (tick) begin
          state_d   = ST_COOLDOWN;
          done_d    = 1'b1;
          elapsed_d = '0;
        end
      end
      default: begin
        if (tick) begin
          if (cd_cnt == CD_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cd_cnt_d = cd_cnt + CD_W'(1);
          end
        end
      end
    endcase

    if (feed_req && (state != ST_IDLE)) begin
      rejected_d = 1'b1;
    end

    // Every state entry restarts a full second and the cooldown count.
    if (state_d != state) begin
      div_clear = 1'b1;
      cd_cnt_d  = '0;
    end

    feed_d     = (state_d == ST_DISPENSE) || (state_d == ST_HOLD);
    motor_en_d = (state_d == ST_DISPENSE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      duration <= '0;
      elapsed  <= '0;
      cd_cnt   <= '0;
      feed     <= 1'b0;
      motor_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rejected <= 1'b0;
    end else begin
      state    <= state_d;
      duration <= duration_d;
      elapsed  <= elapsed_d;
      cd_cnt   <= cd_cnt_d;
      feed     <= feed_d;
      motor_en <= motor_en_d;
      busy     <= busy_d;
      done     <= done_d;
      rejected <= rejected_d;
    end
  end

endmodule
